cache_fill: RTL and testbench

//  Line-fill write stage between fetch_wb and the two-way L1 instruction data RAMs.
//  - Takes fetch_wb's word stream (u_write/u_vld/u_addr/u_data) and buffers it in a 4-entry FIFO.
//  - Writes the words into the selected way when the RAM port is free.
//  - Counts words until the line is complete, then pulses fill_done_o back to cache_ctrl.
//  - Captures the critical (missed) word and hands it to stage 3.

---
 rtl/cache_fill.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_fill.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill.sv
// Line-fill write stage: buffers fetch_wb words in a 4-entry FIFO and writes them into the selected L1 way.
// Optional macro CACHE_FILL_CRIT_FWD_EN forwards the critical word early instead of with fill_done_o.
module cache_fill #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDRESS = 18,
    parameter int unsigned CNTBITS = 4,
    parameter int unsigned INDEX   = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     fill_start_i,
    input  logic [ADDRESS-1:0]       fill_addr_i,
    input  logic                     fill_way_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     fill_done_o,
    input  logic                     u_write_i,
    input  logic                     u_vld_i,
    input  logic [INDEX+CNTBITS-1:0] u_addr_i,
    input  logic [WIDTH-1:0]         u_data_i,
    input  logic                     ram_busy_i,
    output logic                     d_write0_o,
    output logic                     d_write1_o,
    output logic [INDEX+CNTBITS-1:0] d_addr_o,
    output logic [WIDTH-1:0]         d_data_o,
    output logic                     crit_vld_o,
    output logic [WIDTH-1:0]         crit_data_o,
    output logic                     overflow_o,
    output logic                     mismatch_o
);

    localparam int unsigned AW    = INDEX + CNTBITS;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned LW    = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } fifo_word_t;

    state_t             state_q, state_d;
    logic [INDEX-1:0]   line_idx_q, line_idx_d;
    logic [CNTBITS-1:0] crit_off_q, crit_off_d;
    logic [CNTBITS-1:0] count_q, count_d;
    logic               way_q, way_d;
    logic               crit_seen_q, crit_seen_d;
    fifo_word_t         fifo_q [DEPTH];
    fifo_word_t         fifo_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               busy_q, busy_d;
    logic               fill_done_q, fill_done_d;
    logic               crit_vld_q, crit_vld_d;
    logic [WIDTH-1:0]   crit_data_q, crit_data_d;
    logic               overflow_q, overflow_d;
    logic               mismatch_q, mismatch_d;
`ifndef CACHE_FILL_CRIT_FWD_EN
    logic [WIDTH-1:0]   crit_word_q, crit_word_d;
`endif

    logic       push, pop, flush, capture;
    fifo_word_t head;
    logic       unused_addr_bits;

    // Only the index and offset of the miss PC matter to this stage.
    assign unused_addr_bits = ^fill_addr_i[ADDRESS-1:AW];
    assign head             = fifo_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        line_idx_d  = line_idx_q;
        crit_off_d  = crit_off_q;
        count_d     = count_q;
        way_d       = way_q;
        crit_seen_d = crit_seen_q;
        fifo_d      = fifo_q;
        crit_data_d = crit_data_q;
        overflow_d  = overflow_q;
        mismatch_d  = mismatch_q;
`ifndef CACHE_FILL_CRIT_FWD_EN
        crit_word_d = crit_word_q;
`endif
        fill_done_d = 1'b0;
        crit_vld_d  = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        capture     = 1'b0;
        flush       = abort_i;

        case (state_q)
            S_IDLE: begin
                if (fill_start_i && !abort_i) begin
                    state_d     = S_FILL;
                    line_idx_d  = fill_addr_i[AW-1:CNTBITS];
                    crit_off_d  = fill_addr_i[CNTBITS-1:0];
                    way_d       = fill_way_i;
                    count_d     = '0;
                    crit_seen_d = 1'b0;
                    overflow_d  = 1'b0;
                    mismatch_d  = 1'b0;
                    flush       = 1'b1;
                end
            end
            S_FILL: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    pop = (level_q != '0) && !ram_busy_i;
                    if (u_write_i && u_vld_i) begin
                        if (u_addr_i[AW-1:CNTBITS] != line_idx_q) begin
                            mismatch_d = 1'b1;
                        end else if ((level_q == LW'(DEPTH)) && !pop) begin
                            overflow_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    // Writing the last word of the line (count wraps) completes the fill.
                    if (pop) begin
                        count_d = count_q + CNTBITS'(1);
                        if (count_q == '1) begin
                            state_d     = S_DONE;
                            fill_done_d = 1'b1;
                        end
                    end
                    capture = push && (u_addr_i[CNTBITS-1:0] == crit_off_q) && !crit_seen_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            crit_seen_d = 1'b1;
        end
`ifdef CACHE_FILL_CRIT_FWD_EN
        if (capture) begin
            crit_vld_d  = 1'b1;
            crit_data_d = u_data_i;
        end
`else
        if (capture) begin
            crit_word_d = u_data_i;
        end
        if (fill_done_d && crit_seen_q) begin
            crit_vld_d  = 1'b1;
            crit_data_d = crit_word_q;
        end
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = {u_addr_i, u_data_i};
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            level_d  = level_q + LW'(push) - LW'(pop);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            line_idx_q  <= '0;
            crit_off_q  <= '0;
            count_q     <= '0;
            way_q       <= 1'b0;
            crit_seen_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
            crit_vld_q  <= 1'b0;
            crit_data_q <= '0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
`ifndef CACHE_FILL_CRIT_FWD_EN
            crit_word_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            line_idx_q  <= line_idx_d;
            crit_off_q  <= crit_off_d;
            count_q     <= count_d;
            way_q       <= way_d;
            crit_seen_q <= crit_seen_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
            crit_vld_q  <= crit_vld_d;
            crit_data_q <= crit_data_d;
            overflow_q  <= overflow_d;
            mismatch_q  <= mismatch_d;
`ifndef CACHE_FILL_CRIT_FWD_EN
            crit_word_q <= crit_word_d;
`endif
        end
    end

    // RAM write port is driven straight from the FIFO head so a pop writes in the same cycle.
    assign d_write0_o  = pop & ~way_q;
    assign d_write1_o  = pop & way_q;
    assign d_addr_o    = pop ? head.addr : '0;
    assign d_data_o    = pop ? head.data : '0;

    assign busy_o      = busy_q;
    assign fill_done_o = fill_done_q;
    assign crit_vld_o  = crit_vld_q;
    assign crit_data_o = crit_data_q;
    assign overflow_o  = overflow_q;
    assign mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_cache_fill.sv
// Bench for cache_fill: a hand-derived vector table, directed multi-cycle sequences and
// randomized fills, all compared each cycle against a queue-based reference model.
module tb_cache_fill;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ADDR  = 18;
    localparam int unsigned AW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fill_start_i, fill_way_i, abort_i;
    logic [ADDR-1:0]  fill_addr_i;
    logic             busy_o, fill_done_o;
    logic             u_write_i, u_vld_i, ram_busy_i;
    logic [AW-1:0]    u_addr_i;
    logic [WIDTH-1:0] u_data_i;
    logic             d_write0_o, d_write1_o;
    logic [AW-1:0]    d_addr_o;
    logic [WIDTH-1:0] d_data_o;
    logic             crit_vld_o, overflow_o, mismatch_o;
    logic [WIDTH-1:0] crit_data_o;

    always #5 clk = ~clk;

    cache_fill dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .fill_start_i(fill_start_i),
        .fill_addr_i (fill_addr_i),
        .fill_way_i  (fill_way_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .fill_done_o (fill_done_o),
        .u_write_i   (u_write_i),
        .u_vld_i     (u_vld_i),
        .u_addr_i    (u_addr_i),
        .u_data_i    (u_data_i),
        .ram_busy_i  (ram_busy_i),
        .d_write0_o  (d_write0_o),
        .d_write1_o  (d_write1_o),
        .d_addr_o    (d_addr_o),
        .d_data_o    (d_data_o),
        .crit_vld_o  (crit_vld_o),
        .crit_data_o (crit_data_o),
        .overflow_o  (overflow_o),
        .mismatch_o  (mismatch_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a queue of accepted words plus a few scalar facts about the fill.
    localparam int PH_IDLE = 0;
    localparam int PH_FILL = 1;
    localparam int PH_DONE = 2;
    typedef struct { logic [AW-1:0] a; logic [WIDTH-1:0] d; } mw_t;
    mw_t              m_q[$];
    int               m_ph;
    logic [3:0]       m_idx, m_off;
    logic             m_way, m_cfound;
    int               m_written;
    logic [WIDTH-1:0] m_cword, m_cdata;
    logic             m_busy, m_done, m_cvld, m_ovf, m_mis;

    int               n_w0, n_w1, n_done, n_cvld, last_wr, done_cyc, cvld_cyc;
    logic [WIDTH-1:0] cvld_data;
    logic             saw_addr34;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ph = PH_IDLE; m_idx = '0; m_off = '0; m_way = 1'b0; m_cfound = 1'b0;
        m_written = 0; m_cword = '0; m_cdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_cvld = 1'b0; m_ovf = 1'b0; m_mis = 1'b0;
    endtask

    task automatic clr_cnt();
        n_w0 = 0; n_w1 = 0; n_done = 0; n_cvld = 0;
        last_wr = -1; done_cyc = -1; cvld_cyc = -1; cvld_data = '0; saw_addr34 = 1'b0;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, moves one cycle.
    task automatic tick();
        logic ew;
        mw_t  w;
        #1;
        ew = (m_ph == PH_FILL) && !abort_i && (m_q.size() > 0) && !ram_busy_i;
        chk("busy", 64'(busy_o), 64'(m_busy));
        chk("fill_done", 64'(fill_done_o), 64'(m_done));
        chk("crit_vld", 64'(crit_vld_o), 64'(m_cvld));
        chk("crit_data", 64'(crit_data_o), 64'(m_cdata));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("mismatch", 64'(mismatch_o), 64'(m_mis));
        chk("d_write0", 64'(d_write0_o), 64'(ew && !m_way));
        chk("d_write1", 64'(d_write1_o), 64'(ew && m_way));
        chk("d_addr", 64'(d_addr_o), ew ? 64'(m_q[0].a) : 64'(0));
        chk("d_data", 64'(d_data_o), ew ? 64'(m_q[0].d) : 64'(0));
        if (d_write0_o) n_w0++;
        if (d_write1_o) n_w1++;
        if (d_write0_o || d_write1_o) begin
            last_wr = cyc;
            if (d_addr_o == 8'h34) saw_addr34 = 1'b1;
        end
        if (fill_done_o) begin n_done++; done_cyc = cyc; end
        if (crit_vld_o) begin n_cvld++; cvld_cyc = cyc; cvld_data = crit_data_o; end

        m_done = 1'b0;
        m_cvld = 1'b0;
        if (m_ph == PH_IDLE) begin
            if (abort_i) m_q.delete();
            else if (fill_start_i) begin
                m_q.delete();
                m_idx = fill_addr_i[7:4]; m_off = fill_addr_i[3:0]; m_way = fill_way_i;
                m_written = 0; m_cfound = 1'b0; m_ovf = 1'b0; m_mis = 1'b0;
                m_ph = PH_FILL;
            end
        end else if (m_ph == PH_FILL) begin
            if (abort_i) begin
                m_q.delete();
                m_ph = PH_IDLE;
            end else begin
                if (ew) begin w = m_q.pop_front(); m_written++; end
                if (ew && m_written == 16) begin
                    m_ph = PH_DONE;
                    m_done = 1'b1;
`ifndef CACHE_FILL_CRIT_FWD_EN
                    if (m_cfound) begin m_cvld = 1'b1; m_cdata = m_cword; end
`endif
                end
                if (u_write_i && u_vld_i) begin
                    if (u_addr_i[7:4] != m_idx) m_mis = 1'b1;
                    else if (m_q.size() >= 4) m_ovf = 1'b1;
                    else begin
                        w.a = u_addr_i; w.d = u_data_i;
                        m_q.push_back(w);
                        if (u_addr_i[3:0] == m_off && !m_cfound) begin
                            m_cfound = 1'b1;
`ifdef CACHE_FILL_CRIT_FWD_EN
                            m_cvld = 1'b1; m_cdata = u_data_i;
`else
                            m_cword = u_data_i;
`endif
                        end
                    end
                end
            end
        end else begin
            if (abort_i) m_q.delete();
            m_ph = PH_IDLE;
        end
        m_busy = (m_ph != PH_IDLE);
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        fill_start_i = 1'b0; fill_addr_i = '0; fill_way_i = 1'b0; abort_i = 1'b0;
        u_write_i = 1'b0; u_vld_i = 1'b0; u_addr_i = '0; u_data_i = '0; ram_busy_i = 1'b0;
    endtask

    task automatic start_fill(input logic [ADDR-1:0] a, input logic way);
        idle_in(); fill_start_i = 1'b1; fill_addr_i = a; fill_way_i = way; tick();
    endtask

    task automatic word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic rb);
        idle_in(); u_write_i = 1'b1; u_vld_i = 1'b1; u_addr_i = a; u_data_i = d; ram_busy_i = rb; tick();
    endtask

    task automatic gap(input logic rb);
        idle_in(); ram_busy_i = rb; tick();
    endtask

    task automatic do_abort();
        idle_in(); abort_i = 1'b1; tick();
    endtask

    typedef struct {
        logic st; logic [ADDR-1:0] fa; logic way; logic ab;
        logic wr; logic [AW-1:0] ua; logic [WIDTH-1:0] ud; logic rb;
        logic e_busy; logic e_w0; logic e_w1; logic [AW-1:0] e_addr; logic [WIDTH-1:0] e_data; logic e_mis;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st, input logic [ADDR-1:0] fa, input logic way, input logic ab,
                       input logic wr, input logic [AW-1:0] ua, input logic [WIDTH-1:0] ud, input logic rb,
                       input logic eb, input logic e0, input logic e1, input logic [AW-1:0] ea,
                       input logic [WIDTH-1:0] ed, input logic em);
        vec_t v;
        v.st = st; v.fa = fa; v.way = way; v.ab = ab; v.wr = wr; v.ua = ua; v.ud = ud; v.rb = rb;
        v.e_busy = eb; v.e_w0 = e0; v.e_w1 = e1; v.e_addr = ea; v.e_data = ed; v.e_mis = em;
        tbl.push_back(v);
    endtask

    initial begin
        int fp;
        int perm[16];
        logic [ADDR-1:0] ra;
        logic rw;
        int base;

        idle_in();
        rst_n = 1'b0;
        model_reset();
        clr_cnt();
        @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_d_addr", 64'(d_addr_o), 64'(0));
        chk("rst_crit_data", 64'(crit_data_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: start, pushes/pops, foreign index, ignored restart, abort, sticky clear.
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 8'h00, 32'h0,        0);
        add(1, 18'h00035, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 8'h00, 32'h0,        0);
        add(0, 18'h0,     0, 0, 1, 8'h30, 32'h11110000, 0, 1, 0, 0, 8'h00, 32'h0,        0);
        add(0, 18'h0,     0, 0, 1, 8'h31, 32'h11110001, 0, 1, 1, 0, 8'h30, 32'h11110000, 0);
        add(0, 18'h0,     0, 0, 1, 8'h41, 32'hBAD00041, 0, 1, 1, 0, 8'h31, 32'h11110001, 0);
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 8'h00, 32'h0,        1);
        add(1, 18'h00021, 1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 8'h00, 32'h0,        1);
        add(0, 18'h0,     0, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0, 8'h00, 32'h0,        1);
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 8'h00, 32'h0,        1);
        add(1, 18'h00035, 1, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 8'h00, 32'h0,        1);
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 8'h00, 32'h0,        0);
        add(0, 18'h0,     0, 0, 1, 8'h3F, 32'h2222003F, 1, 1, 0, 0, 8'h00, 32'h0,        0);
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 1, 8'h3F, 32'h2222003F, 0);
        add(0, 18'h0,     0, 1, 0, 8'h00, 32'h0,        0, 1, 0, 0, 8'h00, 32'h0,        0);
        add(0, 18'h0,     0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 8'h00, 32'h0,        0);
        foreach (tbl[i]) begin
            idle_in();
            fill_start_i = tbl[i].st; fill_addr_i = tbl[i].fa; fill_way_i = tbl[i].way;
            abort_i = tbl[i].ab; u_write_i = tbl[i].wr; u_vld_i = tbl[i].wr;
            u_addr_i = tbl[i].ua; u_data_i = tbl[i].ud; ram_busy_i = tbl[i].rb;
            #1;
            chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_w0", i), 64'(d_write0_o), 64'(tbl[i].e_w0));
            chk($sformatf("vec%0d_w1", i), 64'(d_write1_o), 64'(tbl[i].e_w1));
            chk($sformatf("vec%0d_addr", i), 64'(d_addr_o), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_data", i), 64'(d_data_o), 64'(tbl[i].e_data));
            chk($sformatf("vec%0d_mis", i), 64'(mismatch_o), 64'(tbl[i].e_mis));
            tick();
        end

        // Full line, way 1, in-order offsets.
        clr_cnt();
        start_fill(18'h00035, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) fp = cyc;
            word({4'h3, 4'(i)}, 32'hF00D0000 + 32'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) gap(1'b0);
        chk("full_w1_count", 64'(n_w1), 64'(16));
        chk("full_w0_count", 64'(n_w0), 64'(0));
        chk("full_done_count", 64'(n_done), 64'(1));
        chk("full_done_latency", 64'(done_cyc), 64'(last_wr + 1));
        chk("full_crit_count", 64'(n_cvld), 64'(1));
        chk("full_crit_data", 64'(cvld_data), 64'(32'hF00D0005));

        // Back-pressure with a dropped fifth word.
        clr_cnt();
        start_fill(18'h00035, 1'b0);
        for (int i = 0; i < 5; i++) word({4'h3, 4'(i)}, 32'hB0000000 + 32'(i), 1'b1);
        chk("bp_overflow_set", 64'(overflow_o), 64'(1));
        for (int i = 5; i < 16; i++) word({4'h3, 4'(i)}, 32'hB0000000 + 32'(i), 1'b0);
        for (int i = 0; i < 6; i++) gap(1'b0);
        chk("bp_writes", 64'(n_w0), 64'(15));
        chk("bp_no_done", 64'(n_done), 64'(0));
        chk("bp_word4_dropped", 64'(saw_addr34), 64'(0));
        chk("bp_still_busy", 64'(busy_o), 64'(1));
        do_abort();

        // Back-pressure released on the fifth word: accepted, line completes.
        clr_cnt();
        start_fill(18'h00035, 1'b0);
        for (int i = 0; i < 4; i++) word({4'h3, 4'(i)}, 32'hC0000000 + 32'(i), 1'b1);
        for (int i = 4; i < 16; i++) word({4'h3, 4'(i)}, 32'hC0000000 + 32'(i), 1'b0);
        for (int i = 0; i < 6; i++) gap(1'b0);
        chk("bp2_overflow", 64'(overflow_o), 64'(0));
        chk("bp2_writes", 64'(n_w0), 64'(16));
        chk("bp2_done", 64'(n_done), 64'(1));

        // Critical word at offset 5, arriving first in wrapped order.
        clr_cnt();
        start_fill(18'h00035, 1'b1);
        fp = cyc;
        for (int i = 0; i < 16; i++) word({4'h3, 4'((i + 5) % 16)}, 32'hCC000000 + 32'((i + 5) % 16), 1'b0);
        for (int i = 0; i < 4; i++) gap(1'b0);
        chk("crit_count", 64'(n_cvld), 64'(1));
        chk("crit_value", 64'(cvld_data), 64'(32'hCC000005));
`ifdef CACHE_FILL_CRIT_FWD_EN
        chk("crit_early_cycle", 64'(cvld_cyc), 64'(fp + 1));
`else
        chk("crit_late_cycle", 64'(cvld_cyc), 64'(done_cyc));
`endif

        // Abort after seven words; afterwards a foreign-index word.
        clr_cnt();
        start_fill(18'h0003C, 1'b0);
        for (int i = 0; i < 7; i++) word({4'h3, 4'(i)}, 32'hAB000000 + 32'(i), 1'b0);
        do_abort();
        chk("abort_busy", 64'(busy_o), 64'(0));
        base = n_w0;
        for (int i = 7; i < 11; i++) word({4'h3, 4'(i)}, 32'hAB000000 + 32'(i), 1'b0);
        gap(1'b0);
        chk("abort_writes_before", 64'(base), 64'(6));
        chk("abort_no_later_writes", 64'(n_w0), 64'(6));
        chk("abort_no_done", 64'(n_done), 64'(0));
        chk("abort_no_crit", 64'(n_cvld), 64'(0));
        clr_cnt();
        start_fill(18'h00035, 1'b0);
        word(8'h45, 32'hDEAD0045, 1'b0);
        gap(1'b0);
        chk("mis_flag", 64'(mismatch_o), 64'(1));
        chk("mis_not_written", 64'(n_w0 + n_w1), 64'(0));
        do_abort();

        // Asynchronous reset mid-fill, then a clean fill.
        clr_cnt();
        start_fill(18'h00035, 1'b1);
        for (int i = 0; i < 5; i++) word({4'h3, 4'(i)}, 32'h55000000 + 32'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy_o), 64'(0));
        chk("mr_w", 64'({d_write0_o, d_write1_o}), 64'(0));
        chk("mr_addr", 64'(d_addr_o), 64'(0));
        chk("mr_data", 64'(d_data_o), 64'(0));
        chk("mr_flags", 64'({fill_done_o, crit_vld_o, overflow_o, mismatch_o}), 64'(0));
        chk("mr_crit_data", 64'(crit_data_o), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clr_cnt();
        start_fill(18'h00035, 1'b1);
        for (int i = 0; i < 16; i++) word({4'h3, 4'(i)}, 32'h66000000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) gap(1'b0);
        chk("mr_refill_writes", 64'(n_w1), 64'(16));
        chk("mr_refill_done", 64'(n_done), 64'(1));

        // Randomized fills against the model.
        for (int f = 0; f < 25; f++) begin
            ra = 18'($urandom);
            rw = 1'($urandom);
            start_fill(ra, rw);
            for (int i = 0; i < 16; i++) perm[i] = i;
            for (int i = 15; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(49, 0) == 0) begin do_abort(); break; end
                while ($urandom_range(3, 0) == 0) gap(1'($urandom_range(2, 0) == 0));
                if ($urandom_range(19, 0) == 0)
                    word({4'(ra[7:4] + 4'd1), 4'(perm[i])}, $urandom, 1'($urandom_range(2, 0) == 0));
                word({ra[7:4], 4'(perm[i])}, $urandom, 1'($urandom_range(2, 0) == 0));
            end
            for (int i = 0; i < 25; i++) gap(1'($urandom_range(3, 0) == 0));
            do_abort();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
